// File: rtl/dmem_arbiter.sv
// Arbitrates the single DataMemory between the core LSU port and a debug/loader port.
// Core wins by default; a saturating wait counter forces a debug grant after MAX_WAIT losses.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_cs,
    input  logic              core_we,
    input  logic [3:0]        core_mask,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [3:0]        dbg_mask,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [3:0]        mem_mask,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  stall_count
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic               grant_dbg;
    logic               grant_core;

    // ACK blocks re-granting a request the master has not yet dropped.
    assign grant_dbg  = dbg_req && (state_q != S_ACK) && (!core_cs || (wait_q == WAIT_MAX));
    assign grant_core = core_cs && !grant_dbg;

    assign core_rdata  = mem_rdata;
    assign core_stall  = core_cs && grant_dbg;
    assign dbg_ack     = (state_q == S_ACK);
    assign dbg_rdata   = rdata_q;
    assign stall_count = stall_q;

    always_comb begin
        mem_cs    = 1'b0;
        mem_we    = 1'b0;
        mem_mask  = 4'b0000;
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
        if (grant_dbg) begin
            mem_cs    = 1'b1;
            mem_we    = dbg_we;
            mem_mask  = dbg_mask;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end else if (grant_core) begin
            mem_cs    = 1'b1;
            mem_we    = core_we;
            mem_mask  = core_mask;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        rdata_d = rdata_q;
        stall_d = stall_q;
        case (state_q)
            S_ACK: state_d = S_IDLE;
            default: begin
                if (grant_dbg) begin
                    state_d = S_ACK;
                    wait_d  = '0;
                    if (!dbg_we) rdata_d = mem_rdata;
                end else if (dbg_req) begin
                    state_d = S_WAIT;
                    if (wait_q != WAIT_MAX) wait_d = wait_q + WAIT_W'(1);
                end else begin
                    state_d = S_IDLE;
                    wait_d  = '0;
                end
            end
        endcase
        if (core_stall && (stall_q != {CNT_W{1'b1}})) stall_d = stall_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            rdata_q <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            rdata_q <= rdata_d;
            stall_q <= stall_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic against a cycle-level model.
module tb_dmem_arbiter;

    localparam int MW   = 4;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic        clk, reset;
    logic        core_cs, core_we, core_stall;
    logic [3:0]  core_mask;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic        dbg_req, dbg_we, dbg_ack;
    logic [3:0]  dbg_mask;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic        mem_cs, mem_we;
    logic [3:0]  mem_mask;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [CW-1:0] stall_count;

    logic [31:0] mem [64];
    int total = 0;
    int bad   = 0;

    assign mem_rdata = mem[mem_addr[5:0]];

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .core_cs(core_cs), .core_we(core_we), .core_mask(core_mask),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
        .core_stall(core_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_mask(dbg_mask),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_mask(mem_mask),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle from the sampling window; the memory applies the write the DUT presented.
    task automatic tick();
        logic w;
        logic [5:0] a;
        logic [31:0] d;
        logic [3:0] m;
        w = mem_cs && mem_we;
        a = mem_addr[5:0];
        d = mem_wdata;
        m = mem_mask;
        @(posedge clk);
        #1;
        if (w) for (int b = 0; b < 4; b++) if (m[b]) mem[a][8*b +: 8] = d[8*b +: 8];
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        core_cs = 0; core_we = 0; core_mask = 0; core_addr = 0; core_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_mask = 0; dbg_addr = 0; dbg_wdata = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        core_cs = 1'($urandom); core_we = 1'($urandom); core_mask = 4'($urandom);
        core_addr = $urandom; core_wdata = $urandom;
        dbg_req = 1'($urandom); dbg_we = 1'($urandom); dbg_mask = 4'($urandom);
        dbg_addr = $urandom; dbg_wdata = $urandom;
        #2;
        tick(); tick();
        #1;
        total++; if (dbg_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", dbg_ack); end
        total++; if (dbg_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", dbg_rdata); end
        total++; if (stall_count !== '0) begin bad++; $display("FAIL reset_stallcnt got=%0d exp=0", stall_count); end
        reset = 1'b1;
        idle_inputs();
        core_cs = 1; core_addr = 32'h44;
        #1;
        total++; if (mem_cs !== 1'b1) begin bad++; $display("FAIL post_reset_cs got=%b exp=1", mem_cs); end
        total++; if (mem_addr !== 32'h44) begin bad++; $display("FAIL post_reset_addr got=%h exp=44", mem_addr); end
        total++; if (core_stall !== 1'b0) begin bad++; $display("FAIL post_reset_stall got=%b exp=0", core_stall); end
        tick();
    endtask

    task automatic test_dbg_read();
        idle_inputs();
        mem[16] = 32'hDEADBEEF;
        dbg_req = 1; dbg_addr = 32'h10;
        #1;
        total++; if (mem_cs !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h10) begin
            bad++; $display("FAIL rd_grant got cs=%b we=%b addr=%h exp cs=1 we=0 addr=10", mem_cs, mem_we, mem_addr);
        end
        tick();
        #1;
        total++; if (dbg_ack !== 1'b1) begin bad++; $display("FAIL rd_ack got=%b exp=1", dbg_ack); end
        total++; if (dbg_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got=%h exp=deadbeef", dbg_rdata); end
        total++; if (mem_cs !== 1'b0) begin bad++; $display("FAIL rd_no_regrant got cs=%b exp=0", mem_cs); end
        dbg_req = 0;
        tick();
        #1;
        total++; if (dbg_ack !== 1'b0) begin bad++; $display("FAIL rd_ack_pulse got=%b exp=0", dbg_ack); end
    endtask

    task automatic test_contention();
        idle_inputs();
        mem[48] = 32'hA5A5A5A5;
        core_cs = 1; core_addr = 32'h8; dbg_req = 1; dbg_addr = 32'h30;
        for (int c = 0; c < MW; c++) begin
            #1;
            total++; if (core_stall !== 1'b0 || mem_addr !== 32'h8 || mem_cs !== 1'b1) begin
                bad++; $display("FAIL cont_core_c%0d got stall=%b addr=%h exp stall=0 addr=8", c, core_stall, mem_addr);
            end
            tick();
        end
        #1;
        total++; if (core_stall !== 1'b1 || mem_addr !== 32'h30) begin
            bad++; $display("FAIL cont_forced got stall=%b addr=%h exp stall=1 addr=30", core_stall, mem_addr);
        end
        tick();
        #1;
        total++; if (dbg_ack !== 1'b1 || core_stall !== 1'b0) begin
            bad++; $display("FAIL cont_ack got ack=%b stall=%b exp ack=1 stall=0", dbg_ack, core_stall);
        end
        total++; if (stall_count !== CW'(1)) begin bad++; $display("FAIL cont_stallcnt got=%0d exp=1", stall_count); end
        total++; if (dbg_rdata !== 32'hA5A5A5A5) begin bad++; $display("FAIL cont_rdata got=%h exp=a5a5a5a5", dbg_rdata); end
        dbg_req = 0;
        tick();
    endtask

    task automatic test_dbg_write();
        idle_inputs();
        mem[32] = 32'h0;
        dbg_req = 1; dbg_we = 1; dbg_mask = 4'b0011; dbg_wdata = 32'h12345678; dbg_addr = 32'h20;
        #1;
        total++; if (mem_cs !== 1'b1 || mem_we !== 1'b1 || mem_mask !== 4'b0011 || mem_wdata !== 32'h12345678) begin
            bad++; $display("FAIL wr_grant got cs=%b we=%b mask=%b wd=%h exp 1 1 0011 12345678", mem_cs, mem_we, mem_mask, mem_wdata);
        end
        tick();
        #1;
        total++; if (dbg_ack !== 1'b1 || mem_we !== 1'b0) begin
            bad++; $display("FAIL wr_ack got ack=%b we=%b exp ack=1 we=0", dbg_ack, mem_we);
        end
        total++; if (dbg_rdata !== 32'hA5A5A5A5) begin bad++; $display("FAIL wr_rdata_kept got=%h exp=a5a5a5a5", dbg_rdata); end
        total++; if (mem[32] !== 32'h00005678) begin bad++; $display("FAIL wr_mem got=%h exp=00005678", mem[32]); end
        dbg_req = 0; dbg_we = 0;
        tick();
    endtask

    task automatic test_reset_in_ack();
        idle_inputs();
        dbg_req = 1; dbg_addr = 32'h10;
        tick();
        #2;
        reset = 1'b0;
        #1;
        total++; if (dbg_ack !== 1'b0) begin bad++; $display("FAIL rst_ack_drop got=%b exp=0", dbg_ack); end
        total++; if (dbg_rdata !== 32'h0) begin bad++; $display("FAIL rst_ack_rdata got=%h exp=0", dbg_rdata); end
        dbg_req = 0;
        tick();
        reset = 1'b1;
        dbg_req = 1;
        #1;
        total++; if (mem_cs !== 1'b1 || mem_addr !== 32'h10) begin
            bad++; $display("FAIL rst_reissue_grant got cs=%b addr=%h exp cs=1 addr=10", mem_cs, mem_addr);
        end
        tick();
        #1;
        total++; if (dbg_ack !== 1'b1 || dbg_rdata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL rst_reissue_ack got ack=%b rd=%h exp ack=1 rd=deadbeef", dbg_ack, dbg_rdata);
        end
        dbg_req = 0;
        tick();
    endtask

    task automatic test_saturation();
        idle_inputs();
        for (int n = 0; n < 5; n++) begin
            core_cs = 1; dbg_req = 1; dbg_addr = 32'h4;
            for (int c = 0; c <= MW; c++) tick();
            dbg_req = 0;
            tick();
            #1;
            total++; if (stall_count !== CW'((n + 1 > CMAX) ? CMAX : n + 1)) begin
                bad++; $display("FAIL sat_round%0d got=%0d exp=%0d", n, stall_count, (n + 1 > CMAX) ? CMAX : n + 1);
            end
        end
    endtask

    // Randomized traffic; the model tracks only what the rules need: how many cycles the pending
    // debug request has been refused, whether this is the ack cycle, and the last read result.
    task automatic test_random();
        int denied, stalls, errs;
        bit ack_now, gd;
        logic [31:0] exp_rd, e_addr, e_wd;
        logic e_cs, e_we;
        logic [3:0] e_mask;
        idle_inputs();
        reset = 1'b0; #2; reset = 1'b1;
        denied = 0; stalls = 0; ack_now = 0; exp_rd = 0; errs = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            core_cs = ($urandom_range(3) != 0); core_we = 1'($urandom);
            core_mask = 4'($urandom); core_addr = $urandom; core_wdata = $urandom;
            if (!dbg_req || dbg_ack) begin
                dbg_req = 1'($urandom); dbg_we = 1'($urandom); dbg_mask = 4'($urandom);
                dbg_addr = $urandom; dbg_wdata = $urandom;
            end
            #1;
            gd = dbg_req && !ack_now && (!core_cs || denied >= MW);
            if (gd) begin
                e_cs = 1; e_we = dbg_we; e_mask = dbg_mask; e_addr = dbg_addr; e_wd = dbg_wdata;
            end else if (core_cs) begin
                e_cs = 1; e_we = core_we; e_mask = core_mask; e_addr = core_addr; e_wd = core_wdata;
            end else begin
                e_cs = 0; e_we = 0; e_mask = 0; e_addr = core_addr; e_wd = core_wdata;
            end
            total++;
            if ({mem_cs, mem_we, mem_mask, mem_addr, mem_wdata} !== {e_cs, e_we, e_mask, e_addr, e_wd}) begin
                bad++;
                if (errs++ < 10) $display("FAIL rnd_mem c%0d got cs=%b we=%b m=%h a=%h d=%h exp cs=%b we=%b m=%h a=%h d=%h",
                    cyc, mem_cs, mem_we, mem_mask, mem_addr, mem_wdata, e_cs, e_we, e_mask, e_addr, e_wd);
            end
            total++;
            if ({core_stall, dbg_ack} !== {core_cs && gd, ack_now}) begin
                bad++;
                if (errs++ < 10) $display("FAIL rnd_ctl c%0d got stall=%b ack=%b exp stall=%b ack=%b",
                    cyc, core_stall, dbg_ack, core_cs && gd, ack_now);
            end
            total++;
            if (dbg_rdata !== exp_rd || stall_count !== CW'((stalls > CMAX) ? CMAX : stalls) || core_rdata !== mem[mem_addr[5:0]]) begin
                bad++;
                if (errs++ < 10) $display("FAIL rnd_regs c%0d got rd=%h cnt=%0d exp rd=%h cnt=%0d",
                    cyc, dbg_rdata, stall_count, exp_rd, (stalls > CMAX) ? CMAX : stalls);
            end
            if (gd && !dbg_we) exp_rd = mem[dbg_addr[5:0]];
            if (gd && core_cs) stalls++;
            if (gd) begin
                ack_now = 1; denied = 0;
            end else if (ack_now) begin
                ack_now = 0;
            end else if (dbg_req) begin
                denied = (denied >= MW) ? MW : denied + 1;
            end else begin
                denied = 0;
            end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        test_reset();
        test_dbg_read();
        test_contention();
        test_dbg_write();
        test_reset_in_ack();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single DataMemory between the pipeline's LoadStoreUnit (core port, MW stage) and a debug/loader port (dbg port).
- Core has default priority. A saturating wait counter guarantees the debug port a grant after MAX_WAIT lost cycles.
- When the core loses arbitration it receives a stall, which freezes the pipeline registers.
- Sits between LoadStoreUnit/DE_MW registers and DataMemory.

Parameters:
- ADDR_W, 32, address width of both ports and memory.
- DATA_W, 32, data width.
- MAX_WAIT, 4, consecutive denied debug cycles before a forced debug grant (>=1).
- CNT_W, 16, width of core stall performance counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- core_cs  in  1  core memory access this cycle (from LSU cs).
- core_we  in  1  core write enable.
- core_mask  in  4  core byte mask.
- core_addr  in  ADDR_W  core address (ALU_DE_MW).
- core_wdata  in  DATA_W  core store data.
- core_rdata  out  DATA_W  mem read data passthrough to LSU.
- core_stall  out  1  core access denied this cycle; pipeline must hold.
- dbg_req  in  1  debug request, held high until dbg_ack.
- dbg_we  in  1  debug write enable (stable while dbg_req).
- dbg_mask  in  4  debug byte mask.
- dbg_addr  in  ADDR_W  debug address.
- dbg_wdata  in  DATA_W  debug store data.
- dbg_ack  out  1  one-cycle pulse, access completed.
- dbg_rdata  out  DATA_W  registered read data, valid with dbg_ack, held until the next ack.
- mem_cs, mem_we  out  1  to DataMemory.
- mem_mask  out  4  to DataMemory.
- mem_addr  out  ADDR_W  to DataMemory.
- mem_wdata  out  DATA_W  to DataMemory.
- mem_rdata  in  DATA_W  DataMemory combinational read data.
- stall_count  out  CNT_W  saturating count of core_stall cycles.

Behaviour:
- FSM states:
  - IDLE: no debug pending.
  - WAIT: dbg_req denied at least once.
  - ACK: ack cycle; debug is ineligible.
- Grant decision is combinational from state and registers:
  - grant_dbg = dbg_req && state!=ACK && (!core_cs || wait_cnt==MAX_WAIT).
  - grant_core = core_cs && !grant_dbg.
- Memory outputs:
  - On grant_dbg: mem_* = dbg_* with mem_cs=1.
  - On grant_core: mem_* = core_*.
  - Otherwise mem_cs=0, mem_we=0, mem_mask=0; addr and wdata follow the core port.
- core_rdata = mem_rdata at all times.
- core_stall = core_cs && grant_dbg (same cycle).
- Transitions:
  - IDLE/WAIT with grant_dbg -> ACK. Capture dbg_rdata <= mem_rdata (reads only; writes leave dbg_rdata unchanged). Clear wait_cnt.
  - IDLE/WAIT with dbg_req && !grant_dbg -> WAIT. wait_cnt increments, saturating at MAX_WAIT.
  - IDLE/WAIT with !dbg_req -> IDLE. wait_cnt=0.
  - ACK -> IDLE unconditionally. dbg_ack=1 for exactly this cycle.
- Latency:
  - Debug access is 1 cycle when uncontended: ack in the cycle after grant.
  - Worst case under continuous core traffic: MAX_WAIT+1 cycles from req to grant.
- ACK state exists so a still-high dbg_req in the ack cycle is not re-granted. Back-to-back debug accesses are therefore at most one per 2 cycles.
- After a forced grant, wait_cnt=0, so the core wins the next contention.
- Simultaneous request from both ports with wait_cnt<MAX_WAIT: core granted, debug waits.
- stall_count increments on each core_stall cycle and saturates at all-ones.
- Reset (async, active-low, any time including mid-ACK):
  - state=IDLE, wait_cnt=0, dbg_ack=0, dbg_rdata=0, stall_count=0.
  - The combinational mem_* outputs then follow the grant rules above.
- An ack in flight when reset asserts is lost. The debug master must re-issue.

Test Plan:
- Reset low with random inputs -> dbg_ack=0, dbg_rdata=0, stall_count=0. After release with dbg_req=0, core_cs=1 -> mem_cs=1, mem_addr=core_addr, core_stall=0.
- Uncontended debug read: core_cs=0, dbg_req=1, dbg_addr=0x10, mem[0x10]=0xDEADBEEF -> mem_cs=1 in cycle 0; dbg_ack=1 and dbg_rdata=0xDEADBEEF in cycle 1; no second grant in cycle 1.
- Contention with MAX_WAIT=4: core_cs held 1, dbg_req held 1 -> core granted cycles 0-3; cycle 4 debug granted and core_stall=1; ack cycle 5; stall_count=1.
- Debug write: dbg_we=1, dbg_mask=4'b0011, dbg_wdata=0x12345678, addr 0x20 -> mem_we=1, mask 0011 for one cycle; dbg_rdata unchanged.
- Reset asserted during ACK -> dbg_ack drops immediately to 0, state IDLE; reissued request completes normally.
- Saturation with CNT_W=2: 5 forced stalls -> stall_count stays 3.
